// File: rtl/serial_acc_bank_if.sv
// Bus bundle for serial_acc_bank: serial frame input, clear/channel control,
// registered read port and per-channel status flags.
interface serial_acc_bank_if #(
  parameter int ACC_W    = 128,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
);
  logic                rx;
  logic                add;
  logic                sub;
  logic                clear;
  logic [CH_W-1:0]     ch;
  logic [CH_W-1:0]     rd_ch;
  logic [ACC_W-1:0]    rd_data;
  logic                busy;
  logic                done;
  logic [CHANNELS-1:0] overflow;
  logic [CHANNELS-1:0] trunc;

  modport master (
    output rx, add, sub, clear, ch, rd_ch,
    input  rd_data, busy, done, overflow, trunc
  );

  modport slave (
    input  rx, add, sub, clear, ch, rd_ch,
    output rd_data, busy, done, overflow, trunc
  );
endinterface

// File: rtl/serial_acc_bank.sv
// Multi-channel serial accumulator: deserialises an MSB-first frame and adds or
// subtracts it into one of CHANNELS accumulators. Define SACC_SATURATE_EN to clamp on overflow.
module serial_acc_bank #(
  parameter int SHIFT_W  = 33,
  parameter int ACC_W    = 128,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  serial_acc_bank_if.slave   bus
);
  localparam int CNT_W = $clog2(SHIFT_W + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [SHIFT_W-1:0]  shift;
  logic [CNT_W-1:0]    cnt;
  logic [CH_W-1:0]     lat_ch;
  logic                lat_sub;
  logic [ACC_W-1:0]    acc [CHANNELS];
  logic [ACC_W-1:0]    rd_q, rd_nxt;
  logic                busy_q, done_q;
  logic [CHANNELS-1:0] ovf_q, trunc_q;

  logic                start, commit, clr, trunc_hit;
  logic [ACC_W-1:0]    cur, result;
  logic [ACC_W:0]      wide;
  logic                wrap;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    commit    = 1'b0;
    clr       = 1'b0;
    trunc_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.add && !bus.clear) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end else if (!bus.add && bus.clear) begin
          clr = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.add) begin
          trunc_hit = (cnt >= CNT_W'(SHIFT_W));
        end else begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commit arithmetic: one extra bit captures carry-out (add) or borrow (sub).
  always_comb begin
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (lat_ch == CH_W'(i)) cur = acc[i];
    end
    wide = lat_sub ? ({1'b0, cur} - {1'b0, ACC_W'(shift)})
                   : ({1'b0, cur} + {1'b0, ACC_W'(shift)});
    wrap = wide[ACC_W];
`ifdef SACC_SATURATE_EN
    if (wrap) result = lat_sub ? '0 : '1;
    else      result = wide[ACC_W-1:0];
`else
    result = wide[ACC_W-1:0];
`endif
  end

  // Out-of-range read channels return zero.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_ch == CH_W'(i)) rd_nxt = acc[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      cnt     <= '0;
      lat_ch  <= '0;
      lat_sub <= 1'b0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= '0;
      trunc_q <= '0;
      // NOTE: the accumulator array is architectural state and must read zero after reset, so it is reset explicitly.
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == SHIFT);
      done_q <= commit;
      rd_q   <= rd_nxt;

      if (start) begin
        shift   <= SHIFT_W'(bus.rx);
        cnt     <= CNT_W'(1);
        lat_ch  <= bus.ch;
        lat_sub <= bus.sub;
      end else if (state == SHIFT && bus.add) begin
        shift <= {shift[SHIFT_W-2:0], bus.rx};
        if (cnt >= CNT_W'(SHIFT_W)) cnt <= CNT_W'(SHIFT_W + 1);
        else                        cnt <= cnt + CNT_W'(1);
      end

      for (int i = 0; i < CHANNELS; i++) begin
        if (commit && lat_ch == CH_W'(i)) begin
          acc[i] <= result;
          if (wrap) ovf_q[i] <= 1'b1;
        end else if (clr && bus.ch == CH_W'(i)) begin
          acc[i]     <= '0;
          ovf_q[i]   <= 1'b0;
          trunc_q[i] <= 1'b0;
        end
        if (trunc_hit && lat_ch == CH_W'(i)) trunc_q[i] <= 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.trunc    = trunc_q;
endmodule

// File: tb/tb_serial_acc_bank.sv
// Self-checking bench for serial_acc_bank: directed and random frames checked
// against an arithmetic reference model of the channel accumulators and flags.
module tb_serial_acc_bank;
  localparam int SHIFT_W  = 33;
  localparam int ACC_W    = 128;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [ACC_W-1:0]    m_acc [CHANNELS];
  logic [CHANNELS-1:0] m_ovf;
  logic [CHANNELS-1:0] m_tr;

  serial_acc_bank_if #(.ACC_W(ACC_W), .CHANNELS(CHANNELS), .CH_W(CH_W)) b ();

  serial_acc_bank #(
    .SHIFT_W(SHIFT_W), .ACC_W(ACC_W), .CHANNELS(CHANNELS), .CH_W(CH_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame value is the last min(n, SHIFT_W) bits sent, read as an unsigned number.
  task automatic model_commit(input int c, input bit s, input logic [63:0] bits, input int n);
    logic [ACC_W-1:0] v;
    int  k;
    bit  ov;
    v = '0;
    k = (n > SHIFT_W) ? SHIFT_W : n;
    for (int i = k - 1; i >= 0; i--) v = (v << 1) | ACC_W'(bits[i]);
    if (n > SHIFT_W) m_tr[c] = 1'b1;
    ov = s ? (v > m_acc[c]) : (v > ~m_acc[c]);
    if (ov) m_ovf[c] = 1'b1;
`ifdef SACC_SATURATE_EN
    if (ov) m_acc[c] = s ? '0 : '1;
    else    m_acc[c] = s ? m_acc[c] - v : m_acc[c] + v;
`else
    m_acc[c] = s ? m_acc[c] - v : m_acc[c] + v;
`endif
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overflow"}, ACC_W'(b.overflow), ACC_W'(m_ovf));
    check({tag, "_trunc"},    ACC_W'(b.trunc),    ACC_W'(m_tr));
  endtask

  // Entered on a negedge; first bit is driven immediately. With tail=0 it
  // returns on the negedge where done is high, so a new frame can start there.
  task automatic send_frame(input int c, input bit s, input logic [63:0] bits, input int n, input bit tail);
    b.add   = 1'b1;
    b.clear = 1'b0;
    b.rx    = bits[n-1];
    b.ch    = CH_W'(c);
    b.sub   = s;
    for (int i = n - 2; i >= 0; i--) begin
      @(negedge clk);
      check("busy_in_frame", ACC_W'(b.busy), ACC_W'(1));
      b.rx    = bits[i];
      b.ch    = CH_W'($urandom);
      b.sub   = 1'($urandom);
      b.clear = 1'($urandom);
    end
    @(negedge clk);
    check("busy_last_bit", ACC_W'(b.busy), ACC_W'(1));
    check("done_in_frame", ACC_W'(b.done), ACC_W'(0));
    b.add   = 1'b0;
    b.clear = 1'b0;
    b.rx    = 1'b0;
    b.ch    = CH_W'($urandom);
    model_commit(c, s, bits, n);
    @(negedge clk);
    check("done_pulse", ACC_W'(b.done), ACC_W'(1));
    check("busy_after_commit", ACC_W'(b.busy), ACC_W'(0));
    if (tail) begin
      b.rd_ch = CH_W'(c);
      @(negedge clk);
      check("done_one_cycle", ACC_W'(b.done), ACC_W'(0));
      check("rd_after_frame", b.rd_data, m_acc[c]);
      check_flags("frame");
    end
  endtask

  task automatic read_check(input int c);
    @(negedge clk);
    b.rd_ch = CH_W'(c);
    @(negedge clk);
    check("rd_channel", b.rd_data, m_acc[c]);
  endtask

  task automatic do_clear(input int c);
    b.add   = 1'b0;
    b.clear = 1'b1;
    b.ch    = CH_W'(c);
    @(negedge clk);
    b.clear = 1'b0;
    m_acc[c] = '0;
    m_ovf[c] = 1'b0;
    m_tr[c]  = 1'b0;
  endtask

  initial begin
    int c, n;
    bit s;
    logic [63:0] bits;

    b.rx = 1'b0; b.add = 1'b0; b.sub = 1'b0; b.clear = 1'b0;
    b.ch = '0;   b.rd_ch = CH_W'(2);
    for (int i = 0; i < CHANNELS; i++) m_acc[i] = '0;
    m_ovf = '0;
    m_tr  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", ACC_W'(b.busy), ACC_W'(0));
    check("rst_done", ACC_W'(b.done), ACC_W'(0));
    check("rst_rd", b.rd_data, '0);
    check_flags("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1011 on ch2, read back two edges after add falls
    send_frame(2, 1'b0, 64'b1011, 4, 1'b1);
    check("ch2_is_11", b.rd_data, ACC_W'(11));
    for (int i = 0; i < CHANNELS; i++) if (i != 2) read_check(i);

    // ch1: add 33-bit all-ones, subtract 5
    @(negedge clk);
    send_frame(1, 1'b0, 64'h1_FFFF_FFFF, 33, 1'b1);
    send_frame(1, 1'b1, 64'h5, 3, 1'b1);
    check("ch1_value", b.rd_data, ACC_W'(64'h1_FFFF_FFFA));
    check("ch1_no_ovf", ACC_W'(b.overflow[1]), ACC_W'(0));

    // ch0 borrow from zero
    send_frame(0, 1'b1, 64'h1, 1, 1'b1);
    check("ch0_borrow_flag", ACC_W'(b.overflow[0]), ACC_W'(1));

    // add and clear together in IDLE: nothing happens
    b.add = 1'b1; b.clear = 1'b1; b.ch = '0; b.rx = 1'b1;
    @(negedge clk);
    check("add_clear_no_busy", ACC_W'(b.busy), ACC_W'(0));
    b.add = 1'b0; b.clear = 1'b0;
    @(negedge clk);
    check("add_clear_no_done", ACC_W'(b.done), ACC_W'(0));
    read_check(0);
    check_flags("add_clear");

    // clear ch0
    @(negedge clk);
    do_clear(0);
    read_check(0);
    check_flags("clear");

    // 35-bit frame on ch3 truncates, then 8-bit 0xFF shows no residue
    @(negedge clk);
    send_frame(3, 1'b0, 64'h5_0000_0003, 35, 1'b1);
    check("trunc3_set", ACC_W'(b.trunc[3]), ACC_W'(1));
    @(negedge clk);
    do_clear(3);
    send_frame(3, 1'b0, 64'hFF, 8, 1'b1);
    check("no_residue", b.rd_data, ACC_W'(8'hFF));

    // Back-to-back frames, second starts while done is high
    send_frame(1, 1'b0, 64'h2D, 6, 1'b0);
    send_frame(1, 1'b0, 64'h7, 3, 1'b1);

    // Randomised frames
    for (int t = 0; t < 30; t++) begin
      c    = int'($urandom_range(0, CHANNELS - 1));
      s    = 1'($urandom);
      n    = int'($urandom_range(1, 40));
      bits = {$urandom, $urandom};
      send_frame(c, s, bits, n, 1'($urandom));
    end
    for (int i = 0; i < CHANNELS; i++) read_check(i);
    check_flags("random");

    // Reset mid-frame after 10 bits
    @(negedge clk);
    b.add = 1'b1; b.ch = CH_W'(1); b.sub = 1'b0; b.rx = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b.rx = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", ACC_W'(b.busy), ACC_W'(0));
    check("midrst_done", ACC_W'(b.done), ACC_W'(0));
    b.add = 1'b0;
    for (int i = 0; i < CHANNELS; i++) m_acc[i] = '0;
    m_ovf = '0;
    m_tr  = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", ACC_W'(b.done), ACC_W'(0));
    for (int i = 0; i < CHANNELS; i++) read_check(i);
    check_flags("midrst");

    // 3-bit frame 101 after reset
    @(negedge clk);
    send_frame(2, 1'b0, 64'b101, 3, 1'b1);
    check("post_rst_frame", b.rd_data, ACC_W'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
